// File: rtl/demux_dispatch_if.sv
// demux_dispatch_if: handshake and data bundle between producer, dispatcher and the four demux channels
interface demux_dispatch_if #(parameter int DW = 8);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_dest;
  logic          mode;
  logic [1:0]    sel;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    reroute_cnt;
  modport master (
    output in_valid, in_data, in_dest, mode, out_ready,
    input  in_ready, sel, out_valid, out_data, reroute_cnt
  );
  modport slave (
    input  in_valid, in_data, in_dest, mode, out_ready,
    output in_ready, sel, out_valid, out_data, reroute_cnt
  );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: 1-entry buffered 1:4 dispatcher, round-robin or addressed, with stall re-route
module demux_dispatch_ctrl #(
  parameter int DW = 8,
  parameter int STALL_MAX = 4
) (
  input logic clk,
  input logic rst,
  demux_dispatch_if.slave bus
);
  localparam int SW = $clog2(STALL_MAX) + 1;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t        state, state_n;
  logic [1:0]    sel, rr_ptr, rr_next;
  logic [DW-1:0] data;
  logic          held_mode;
  logic [SW-1:0] stall_cnt;
  logic [7:0]    reroute_cnt;
  logic          in_ready, accept, deliver, stall, reroute;
  always_comb begin
    deliver  = state == HOLD && bus.out_ready[sel];
    stall    = state == HOLD && !bus.out_ready[sel];
    in_ready = !rst && (state == IDLE || bus.out_ready[sel]);
    accept   = bus.in_valid && in_ready;
    reroute  = stall && !held_mode && stall_cnt == SW'(STALL_MAX - 1);
    // the pointer moves past the delivered channel before a same-cycle accept picks its target
    rr_next  = deliver && !held_mode ? sel + 2'd1 : rr_ptr;
    state_n  = accept ? HOLD : deliver ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      rr_ptr      <= '0;
      data        <= '0;
      held_mode   <= 1'b0;
      stall_cnt   <= '0;
      reroute_cnt <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_next;
      if (accept) begin
        sel       <= bus.mode ? bus.in_dest : rr_next;
        data      <= bus.in_data;
        held_mode <= bus.mode;
        stall_cnt <= '0;
      end else if (reroute) begin
        sel         <= sel + 2'd1;
        stall_cnt   <= '0;
        reroute_cnt <= reroute_cnt + 8'(reroute_cnt != 8'hFF);
      end else if (stall) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
  assign bus.in_ready    = in_ready;
  assign bus.sel         = sel;
  assign bus.out_valid   = state == HOLD ? 4'b0001 << sel : 4'b0000;
  assign bus.out_data    = data;
  assign bus.reroute_cnt = reroute_cnt;
endmodule
